// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the FSM state enum, register-address width and the x0 constant.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports: clk_i, rst_ni (async low), inc_i, cnt_o[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use, taken branch, memory-miss freeze
// with timeout FSM, sticky error and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              IDEX_MemRead_i,
  input  logic [REG_AW-1:0] IDEX_RDaddr_i,
  input  logic [REG_AW-1:0] IFID_RS1addr_i,
  input  logic [REG_AW-1:0] IFID_RS2addr_i,
  input  logic              Branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              PCWrite_o,
  output logic              IFID_Stall_o,
  output logic              IFID_Flush_o,
  output logic              IDEX_Bubble_o,
  output logic              Freeze_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  logic load_use;
  logic freeze;
  logic lu_only;
  logic br_only;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d = RUN;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign load_use = IDEX_MemRead_i
                  && (IDEX_RDaddr_i != REG_X0)
                  && ((IDEX_RDaddr_i == IFID_RS1addr_i)
                   || (IDEX_RDaddr_i == IFID_RS2addr_i));

  // A same-cycle ack is a hit, so only an unacked request freezes.
  assign freeze  = (mem_req_i && !mem_ack_i) || (state_q == ERR);
  assign lu_only = !freeze && load_use;
  assign br_only = !freeze && !load_use && Branch_taken_i;

  always_comb begin
    PCWrite_o     = 1'b1;
    IFID_Stall_o  = 1'b0;
    IFID_Flush_o  = 1'b0;
    IDEX_Bubble_o = 1'b0;
    unique case (1'b1)
      freeze: begin
        PCWrite_o    = 1'b0;
        IFID_Stall_o = 1'b1;
      end
      lu_only: begin
        PCWrite_o     = 1'b0;
        IFID_Stall_o  = 1'b1;
        IDEX_Bubble_o = 1'b1;
      end
      br_only: begin
        IFID_Flush_o = 1'b1;
      end
      default: begin
        PCWrite_o = 1'b1;
      end
    endcase
  end

  assign Freeze_o = freeze;
  assign err_o    = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (start_i),
    .inc_i  (freeze || load_use),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (start_i),
    .inc_i  (IFID_Flush_o),
    .cnt_o  (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (small and default
// parameters) checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mr = 1'b0;
  logic [4:0] rd = '0;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic       br = 1'b0;
  logic       req = 1'b0;
  logic       ack = 1'b0;

  logic        pcw_a, stl_a, fl_a, bub_a, frz_a, err_a;
  logic [1:0]  sc_a, fc_a;
  logic        pcw_b, stl_b, fl_b, bub_b, frz_b, err_b;
  logic [15:0] sc_b, fc_b;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(2)) dut_a (
    .clk_i(clk), .start_i(rst_n),
    .IDEX_MemRead_i(mr), .IDEX_RDaddr_i(rd),
    .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2),
    .Branch_taken_i(br), .mem_req_i(req), .mem_ack_i(ack),
    .PCWrite_o(pcw_a), .IFID_Stall_o(stl_a), .IFID_Flush_o(fl_a),
    .IDEX_Bubble_o(bub_a), .Freeze_o(frz_a), .err_o(err_a),
    .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
  );

  pipeline_hazard_ctrl dut_b (
    .clk_i(clk), .start_i(rst_n),
    .IDEX_MemRead_i(mr), .IDEX_RDaddr_i(rd),
    .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2),
    .Branch_taken_i(br), .mem_req_i(req), .mem_ack_i(ack),
    .PCWrite_o(pcw_b), .IFID_Stall_o(stl_b), .IFID_Flush_o(fl_b),
    .IDEX_Bubble_o(bub_b), .Freeze_o(frz_b), .err_o(err_b),
    .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
  );

  // Model: per instance, wait-in-progress flag, cycles waited so far,
  // error flag and plain integer counters.
  int maxw[2] = '{4, 64};
  int cmax[2] = '{3, 65535};
  bit m_inwait[2];
  int m_waited[2];
  bit m_err[2];
  int m_stall[2];
  int m_flush[2];

  function automatic bit m_lu();
    return mr && (rd != 0) && (rd == rs1 || rd == rs2);
  endfunction

  function automatic bit m_fz(input int k);
    return (req && !ack) || m_err[k];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_inwait[k] = 0;
        m_waited[k] = 0;
        m_err[k] = 0;
        m_stall[k] = 0;
        m_flush[k] = 0;
      end else begin
        if (m_fz(k) || m_lu()) begin
          if (m_stall[k] < cmax[k]) m_stall[k]++;
        end else if (br) begin
          if (m_flush[k] < cmax[k]) m_flush[k]++;
        end
        if (!m_err[k]) begin
          if (m_inwait[k]) begin
            if (ack) m_inwait[k] = 0;
            else if (m_waited[k] == maxw[k] - 1) m_err[k] = 1;
            else m_waited[k]++;
          end else if (req && !ack) begin
            m_inwait[k] = 1;
            m_waited[k] = 0;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic pcw, input logic stl,
                          input logic fl, input logic bub,
                          input logic frz, input logic er,
                          input int sc, input int fc);
    bit fz, lu;
    string p;
    fz = m_fz(k);
    lu = m_lu();
    p = (k == 0) ? "a" : "b";
    cmp({p, ".PCWrite"}, int'(pcw), int'(!fz && !lu));
    cmp({p, ".Stall"}, int'(stl), int'(fz || lu));
    cmp({p, ".Flush"}, int'(fl), int'(!fz && !lu && br));
    cmp({p, ".Bubble"}, int'(bub), int'(!fz && lu));
    cmp({p, ".Freeze"}, int'(frz), int'(fz));
    cmp({p, ".err"}, int'(er), int'(m_err[k]));
    cmp({p, ".stall_cnt"}, sc, m_stall[k]);
    cmp({p, ".flush_cnt"}, fc, m_flush[k]);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, pcw_a, stl_a, fl_a, bub_a, frz_a, err_a,
             int'(sc_a), int'(fc_a));
    cmp_inst(1, pcw_b, stl_b, fl_b, bub_b, frz_b, err_b,
             int'(sc_b), int'(fc_b));
  end

  task automatic drive(input logic i_mr, input logic [4:0] i_rd,
                       input logic [4:0] i_rs1, input logic [4:0] i_rs2,
                       input logic i_br, input logic i_req,
                       input logic i_ack);
    @(posedge clk);
    #1;
    mr = i_mr; rd = i_rd; rs1 = i_rs1; rs2 = i_rs2;
    br = i_br; req = i_req; ack = i_ack;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    settle();
    cmp("lit.reset_pcw", int'(pcw_a), 1);
    cmp("lit.reset_stall_cnt", int'(sc_a), 0);
    cmp("lit.reset_err", int'(err_b), 0);

    drive(1, 5, 0, 5, 0, 0, 0);
    settle();
    cmp("lit.lu_stall", int'(stl_a), 1);
    cmp("lit.lu_bubble", int'(bub_a), 1);
    cmp("lit.lu_pcw", int'(pcw_a), 0);
    idle();
    settle();
    cmp("lit.lu_cnt", int'(sc_b), 1);

    drive(1, 0, 0, 0, 0, 0, 0);
    settle();
    cmp("lit.x0_nostall", int'(stl_b), 0);

    drive(1, 7, 7, 0, 1, 0, 0);
    settle();
    cmp("lit.br_suppressed", int'(fl_b), 0);
    drive(0, 7, 7, 0, 1, 0, 0);
    settle();
    cmp("lit.br_flush", int'(fl_b), 1);
    idle();
    settle();
    cmp("lit.flush_cnt", int'(fc_b), 1);
    cmp("lit.stall_cnt2", int'(sc_b), 2);

    rst_pulse();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      settle();
      cmp("lit.miss_freeze", int'(frz_b), 1);
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    settle();
    cmp("lit.ack_release", int'(frz_b), 0);
    cmp("lit.ack_pcw", int'(pcw_b), 1);
    idle();
    settle();
    cmp("lit.miss_stall_cnt", int'(sc_b), 3);

    rst_pulse();
    repeat (5) drive(0, 0, 0, 0, 0, 1, 0);
    idle();
    settle();
    cmp("lit.timeout_err", int'(err_a), 1);
    cmp("lit.err_freeze", int'(frz_a), 1);
    cmp("lit.b_no_err", int'(err_b), 0);
    drive(0, 0, 0, 0, 0, 1, 1);
    settle();
    cmp("lit.err_hold", int'(frz_a), 1);
    rst_pulse();
    cmp("lit.err_cleared", int'(err_a), 0);

    repeat (2) drive(0, 0, 0, 0, 0, 1, 0);
    rst_pulse();
    idle();
    settle();
    cmp("lit.midwait_rst", int'(frz_a), 0);

    rst_pulse();
    repeat (5) drive(1, 3, 3, 0, 0, 0, 0);
    idle();
    settle();
    cmp("lit.sat_a", int'(sc_a), 3);
    cmp("lit.nosat_b", int'(sc_b), 5);

    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 5'((i * 7) % 32), (i % 4 == 0) ? 5'(i) : 5'd0,
            1'(i % 2), (i % 5 == 0), (i % 10 == 0));
    end
    idle();
    settle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the IF/ID register's Stall/Flush inputs, PC write enable, ID/EX bubble insertion and a global freeze for data-memory misses.
- Detects load-use hazards and taken-branch flushes, and sequences multi-cycle memory waits through an FSM with timeout.
- Keeps saturating performance counters.

Parameters:
- MAX_WAIT, 64, cycles permitted in MEM_WAIT before declaring a timeout error.
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk_i  in  1  clock
- start_i  in  1  asynchronous active-low reset
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_RDaddr_i  in  5  destination register of the instruction in EX
- IFID_RS1addr_i  in  5  rs1 of the instruction in ID
- IFID_RS2addr_i  in  5  rs2 of the instruction in ID
- Branch_taken_i  in  1  branch in ID resolved taken
- mem_req_i  in  1  MEM stage issues a data-memory access this cycle
- mem_ack_i  in  1  data memory completes the access (same cycle = hit)
- PCWrite_o  out  1  PC update enable
- IFID_Stall_o  out  1  hold IF/ID
- IFID_Flush_o  out  1  zero IF/ID
- IDEX_Bubble_o  out  1  insert NOP into ID/EX
- Freeze_o  out  1  hold all pipeline registers and the PC
- err_o  out  1  sticky memory timeout error
- stall_cnt_o  out  CNT_W  count of stall cycles
- flush_cnt_o  out  CNT_W  count of flush cycles

Behaviour:
- Clock clk_i; reset start_i is asynchronous and active-low. Reset: state RUN, wait_cnt=0, err_o=0, both counters 0.
- FSM states:
  - RUN -> MEM_WAIT when mem_req_i & ~mem_ack_i.
  - MEM_WAIT -> RUN on mem_ack_i.
  - MEM_WAIT -> ERR when ~mem_ack_i & wait_cnt==MAX_WAIT-1.
  - ERR is terminal until reset.
- wait_cnt: cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle without ack.
- Control outputs are combinational from state and inputs (IF/ID samples them at the edge), so there is zero-cycle latency.
- Freeze_o = (mem_req_i & ~mem_ack_i) | (state==ERR). A hit (req with ack in the same cycle) does not freeze.
- load_use = IDEX_MemRead_i & IDEX_RDaddr_i!=0 & (IDEX_RDaddr_i==IFID_RS1addr_i | IDEX_RDaddr_i==IFID_RS2addr_i).
- Priority: Freeze > load_use > Branch_taken_i.
  - Freeze: PCWrite_o=0, IFID_Stall_o=1, IFID_Flush_o=0, IDEX_Bubble_o=0. Downstream registers hold via Freeze_o.
  - load_use (no freeze): PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1, IFID_Flush_o=0. The branch is suppressed and re-evaluated next cycle.
  - Branch_taken_i only: IFID_Flush_o=1, PCWrite_o=1, IFID_Stall_o=0, IDEX_Bubble_o=0.
  - None: PCWrite_o=1, all others 0.
- IFID_Stall_o and IFID_Flush_o are never both 1.
- In MEM_WAIT the ack cycle itself releases the freeze: outputs follow the non-freeze rules in that cycle.
- stall_cnt_o increments on every cycle with Freeze_o | load_use-stall.
- flush_cnt_o increments on every cycle with IFID_Flush_o=1.
- Both counters saturate at all-ones and do not wrap.
- err_o is set on the transition to ERR and stays 1 until reset.
- Reset asserted mid-wait: immediate return to RUN, all outputs at reset values. Combinational outputs then follow the inputs with state=RUN.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT, ERR};
  - register-address width constant REG_AW=5;
  - the x0 constant.
- Natural sub-module: sat_counter, a parameterised saturating counter instantiated twice.
- Hazard comparison stays inline.

Test Plan:
- Reset release with all inputs 0 -> PCWrite_o=1, other controls 0, counters 0, err_o=0.
- IDEX_MemRead_i=1, IDEX_RDaddr_i=5, IFID_RS2addr_i=5 for 1 cycle -> PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1, stall_cnt_o=1 next cycle. Repeat with RDaddr=0 -> no stall.
- Branch_taken_i=1 with load_use active -> no flush. Next cycle load_use clear, branch still 1 -> IFID_Flush_o=1, flush_cnt_o=1.
- mem_req_i=1, mem_ack_i=0 for 3 cycles then ack -> Freeze_o=1 for 3 cycles, 0 on the ack cycle. State returns to RUN; stall_cnt_o=3.
- MAX_WAIT=4, mem_req_i held with no ack -> ERR after 4 wait cycles, err_o=1, Freeze_o stays 1. Pulsing start_i low -> RUN, err_o=0.
- CNT_W=2, 5 consecutive stall cycles -> stall_cnt_o saturates at 3.
